// File: rtl/mac_add_pkg.sv
// Shared definitions for the pipelined MAC adder.
//   op_t     : 2-bit operation select carried alongside each op in the pipe
//   OP_*     : operation encodings (ADD, ACC, LOAD, SUB)
//   isAccOp  : true for ops that read and later rewrite the accumulator
package mac_add_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD  = 2'b00;
    localparam op_t OP_ACC  = 2'b01;
    localparam op_t OP_LOAD = 2'b10;
    localparam op_t OP_SUB  = 2'b11;

    // ACC and LOAD both end up writing acc_q, so they share the hazard logic.
    function automatic logic isAccOp(input op_t op);
        return (op == OP_ACC) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/seg_adder.sv
// One carry-chain segment: a plain ripple of SEG_W full-adder cells.
// Ports:
//   x, y   in  SEG_W  segment operands
//   cin    in  1      carry into bit 0
//   s      out SEG_W  segment sum
//   cout   out 1      carry out of the segment MSB
//   c_msb  out 1      carry into the segment MSB (signed overflow on the top segment)
module seg_adder #(
    parameter int SEG_W = 16
) (
    input  logic [SEG_W-1:0] x,
    input  logic [SEG_W-1:0] y,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [SEG_W:0] w_carry;

    // Bit-serial ripple; w_carry[i] is the carry into bit i, so the last two
    // entries give both the carry out and the carry into the MSB.
    always_comb begin
        w_carry    = '0;
        s          = '0;
        w_carry[0] = cin;
        for (int i = 0; i < SEG_W; i++) begin
            s[i]         = x[i] ^ y[i] ^ w_carry[i];
            w_carry[i+1] = (x[i] & y[i]) | (w_carry[i] & (x[i] ^ y[i]));
        end
    end

    assign cout  = w_carry[SEG_W];
    assign c_msb = w_carry[SEG_W-1];

endmodule

// File: rtl/mac_pipe_adder.sv
// Pipelined replacement for the MAC unit's ripple adder. The WIDTH-bit carry
// chain is cut into NSEG = WIDTH/SEG_W segments, one registered stage each,
// with an elastic valid/ready handshake on both sides and an internal
// accumulator for the ACC/LOAD ops.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  input handshake; in_ready never depends on in_valid
//   in_op                00 ADD, 01 ACC, 10 LOAD, 11 SUB
//   in_a, in_b, in_cin   operands and carry-in (b/cin only used by ADD/SUB)
//   out_valid/out_ready  output handshake
//   out_sum              {carry_out, sum}
//   out_ovf              signed overflow of the full-width add
//   acc_q                accumulator, written when an ACC/LOAD result retires
module mac_pipe_adder
    import mac_add_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_ovf,
    output logic [WIDTH-1:0] acc_q
);

    localparam int NSEG = WIDTH / SEG_W;

    if ((WIDTH % SEG_W) != 0 || NSEG < 1) begin : g_widthCheck
        $error("mac_pipe_adder: WIDTH must be a non-zero multiple of SEG_W");
    end

    // Stage k registers: x/y still hold the not-yet-added upper segments,
    // r_s holds the already-computed lower segments, r_c is the carry into
    // segment k.
    logic             r_v  [NSEG];
    op_t              r_op [NSEG];
    logic             r_c  [NSEG];
    logic [WIDTH-1:0] r_x  [NSEG];
    logic [WIDTH-1:0] r_y  [NSEG];
    logic [WIDTH-1:0] r_s  [NSEG];

    logic             r_accBusy;
    logic             r_outIsAcc;

    logic [SEG_W-1:0] w_segSum  [NSEG];
    logic             w_segCout [NSEG];
    logic             w_segCmsb [NSEG];
    logic [WIDTH-1:0] w_merged  [NSEG];

    logic             w_stall;
    logic             w_accept;
    logic             w_retire;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_c0;

    assign w_stall  = out_valid && !out_ready;
    assign in_ready = !w_stall && !r_accBusy;
    assign w_accept = in_valid && in_ready;
    assign w_retire = out_valid && out_ready;

    // Operand selection at the pipe entry. SUB is a + ~b + 1, ACC folds the
    // current accumulator in as the second operand, LOAD adds zero.
    always_comb begin
        w_x  = in_a;
        w_y  = in_b;
        w_c0 = in_cin;
        case (in_op)
            OP_SUB: begin
                w_y  = ~in_b;
                w_c0 = 1'b1;
            end
            OP_ACC: begin
                w_y  = acc_q;
                w_c0 = 1'b0;
            end
            OP_LOAD: begin
                w_y  = '0;
                w_c0 = 1'b0;
            end
            default: begin
                w_y  = in_b;
                w_c0 = in_cin;
            end
        endcase
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        seg_adder #(
            .SEG_W (SEG_W)
        ) u_seg (
            .x     (r_x[k][k*SEG_W +: SEG_W]),
            .y     (r_y[k][k*SEG_W +: SEG_W]),
            .cin   (r_c[k]),
            .s     (w_segSum[k]),
            .cout  (w_segCout[k]),
            .c_msb (w_segCmsb[k])
        );
    end

    // Drop each stage's freshly computed segment into its partial result so
    // the next stage (or the output register) sees all segments so far.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            w_merged[k]                    = r_s[k];
            w_merged[k][k*SEG_W +: SEG_W] = w_segSum[k];
        end
    end

    // Pipeline, output register and accumulator. Every stage advances together
    // unless the output is stalled; bubbles are moved like ops so latency is
    // fixed at NSEG. acc_busy spans from accepting an ACC/LOAD until its
    // result retires, which keeps a single accumulator op in flight and lets
    // the next ACC read an up-to-date acc_q at the pipe entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSEG; k++) begin
                r_v[k]  <= 1'b0;
                r_op[k] <= OP_ADD;
                r_c[k]  <= 1'b0;
                r_x[k]  <= '0;
                r_y[k]  <= '0;
                r_s[k]  <= '0;
            end
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_ovf    <= 1'b0;
            r_outIsAcc <= 1'b0;
            r_accBusy  <= 1'b0;
            acc_q      <= '0;
        end else begin
            if (!w_stall) begin
                r_v[0] <= w_accept;
                if (w_accept) begin
                    r_op[0] <= in_op;
                    r_x[0]  <= w_x;
                    r_y[0]  <= w_y;
                    r_c[0]  <= w_c0;
                    r_s[0]  <= '0;
                end
                for (int k = 1; k < NSEG; k++) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1]) begin
                        r_op[k] <= r_op[k-1];
                        r_x[k]  <= r_x[k-1];
                        r_y[k]  <= r_y[k-1];
                        r_c[k]  <= w_segCout[k-1];
                        r_s[k]  <= w_merged[k-1];
                    end
                end
                out_valid <= r_v[NSEG-1];
                if (r_v[NSEG-1]) begin
                    out_sum    <= {w_segCout[NSEG-1], w_merged[NSEG-1]};
                    out_ovf    <= w_segCmsb[NSEG-1] ^ w_segCout[NSEG-1];
                    r_outIsAcc <= isAccOp(r_op[NSEG-1]);
                end
            end

            if (w_accept && isAccOp(in_op)) begin
                r_accBusy <= 1'b1;
            end else if (w_retire && r_outIsAcc) begin
                r_accBusy <= 1'b0;
            end

            if (w_retire && r_outIsAcc) begin
                acc_q <= out_sum[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe_adder.sv
// Self-checking bench for mac_pipe_adder: directed vector table and
// multi-cycle sequences on a 64/16 instance, plus randomized traffic on
// 64/16, 32/32 and 48/8 instances against a transaction-level model.
module tb_mac_pipe_adder;
    import mac_add_pkg::*;

    localparam int W    = 64;
    localparam int SEG  = 16;
    localparam int NSEG = W / SEG;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          inVal;
    logic          inReady;
    logic [1:0]    inOp;
    logic [W-1:0]  inA;
    logic [W-1:0]  inB;
    logic          inCin;
    logic          outValid;
    logic          outReady;
    logic [W:0]    outSum;
    logic          outOvf;
    logic [W-1:0]  accQ;

    int checks   = 0;
    int failures = 0;

    mac_pipe_adder #(.WIDTH(W), .SEG_W(SEG)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inVal),
        .in_ready  (inReady),
        .in_op     (inOp),
        .in_a      (inA),
        .in_b      (inB),
        .in_cin    (inCin),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_sum   (outSum),
        .out_ovf   (outOvf),
        .acc_q     (accQ)
    );

    task automatic checkOutput(input string name, input logic [64:0] actual, input logic [64:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Presents one op at a negedge, expects it to be accepted on the next
    // rising edge, and returns at the negedge after that edge with in_valid low.
    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(negedge clk);
        inVal = 1'b1;
        inOp  = op;
        inA   = a;
        inB   = b;
        inCin = cin;
        #1;
        checkOutput("acceptReady", 65'(inReady), 65'(1));
        @(posedge clk);
        @(negedge clk);
        inVal = 1'b0;
    endtask

    task automatic waitOutValid(input string name);
        int n;
        n = 0;
        while (!outValid && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 65'(outValid), 65'(1));
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W:0]   expSum;
        logic         expOvf;
        logic [W-1:0] expAcc;
    } vec_t;

    vec_t vecs[10];

    // Randomized sweep: each configuration has its own DUT and model. The
    // model tracks ops as a queue; an op becomes visible at the output after
    // NSEG non-stalled edges have passed since its accept edge.
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int GW = (g == 0) ? 64 : (g == 1) ? 32 : 48;
        localparam int GS = (g == 0) ? 16 : (g == 1) ? 32 : 8;
        localparam int GN = GW / GS;

        logic          sRst_n;
        logic          sInVal;
        logic          sInReady;
        logic [1:0]    sOp;
        logic [GW-1:0] sA;
        logic [GW-1:0] sB;
        logic          sCin;
        logic          sOutValid;
        logic          sOutReady;
        logic [GW:0]   sOutSum;
        logic          sOutOvf;
        logic [GW-1:0] sAccQ;
        logic          done = 1'b0;

        logic [GW:0]   expSumQ[$];
        logic          expOvfQ[$];
        logic          isAccQ[$];
        int            tagQ[$];
        logic [GW-1:0] modelAcc;
        logic          modelBusy;
        logic [GW-1:0] y;
        logic          c;
        logic [GW:0]   full;
        logic [63:0]   r;
        logic          expValid;
        logic          expStall;
        logic          expReady;
        int            adv;

        mac_pipe_adder #(.WIDTH(GW), .SEG_W(GS)) u_dut (
            .clk       (clk),
            .rst_n     (sRst_n),
            .in_valid  (sInVal),
            .in_ready  (sInReady),
            .in_op     (sOp),
            .in_a      (sA),
            .in_b      (sB),
            .in_cin    (sCin),
            .out_valid (sOutValid),
            .out_ready (sOutReady),
            .out_sum   (sOutSum),
            .out_ovf   (sOutOvf),
            .acc_q     (sAccQ)
        );

        initial begin
            sRst_n    = 1'b0;
            sInVal    = 1'b0;
            sOutReady = 1'b1;
            sOp       = OP_ADD;
            sA        = '0;
            sB        = '0;
            sCin      = 1'b0;
            modelAcc  = '0;
            modelBusy = 1'b0;
            adv       = 0;
            repeat (3) @(negedge clk);
            sRst_n = 1'b1;
            for (int cyc = 0; cyc < 600; cyc++) begin
                @(negedge clk);
                checkOutput($sformatf("cfg%0d accQ", g), 65'(sAccQ), 65'(modelAcc));
                sInVal = (cyc < 560) && ($urandom_range(0, 3) != 0);
                sOp    = 2'($urandom_range(0, 3));
                r      = {$urandom(), $urandom()};
                sA     = ($urandom_range(0, 7) == 0) ? '1 : r[GW-1:0];
                r      = {$urandom(), $urandom()};
                sB     = r[GW-1:0];
                sCin   = 1'($urandom_range(0, 1));
                sOutReady = (cyc >= 560) || ($urandom_range(0, 3) != 0);
                #1;
                expValid = (tagQ.size() > 0) && (adv >= tagQ[0]);
                expStall = expValid && !sOutReady;
                expReady = !expStall && !modelBusy;
                checkOutput($sformatf("cfg%0d outValid", g), 65'(sOutValid), 65'(expValid));
                checkOutput($sformatf("cfg%0d inReady", g), 65'(sInReady), 65'(expReady));
                if (expValid && sOutReady) begin
                    checkOutput($sformatf("cfg%0d sum", g), 65'(sOutSum), 65'(expSumQ[0]));
                    checkOutput($sformatf("cfg%0d ovf", g), 65'(sOutOvf), 65'(expOvfQ[0]));
                    if (isAccQ[0]) begin
                        modelAcc  = expSumQ[0][GW-1:0];
                        modelBusy = 1'b0;
                    end
                    void'(expSumQ.pop_front());
                    void'(expOvfQ.pop_front());
                    void'(isAccQ.pop_front());
                    void'(tagQ.pop_front());
                end
                if (sInVal && expReady) begin
                    case (sOp)
                        OP_SUB:  begin y = ~sB;      c = 1'b1; end
                        OP_ACC:  begin y = modelAcc; c = 1'b0; end
                        OP_LOAD: begin y = '0;       c = 1'b0; end
                        default: begin y = sB;       c = sCin; end
                    endcase
                    full = {1'b0, sA} + {1'b0, y} + (GW+1)'(c);
                    expSumQ.push_back(full);
                    expOvfQ.push_back((sA[GW-1] == y[GW-1]) && (full[GW-1] != sA[GW-1]));
                    isAccQ.push_back((sOp == OP_ACC) || (sOp == OP_LOAD));
                    tagQ.push_back(adv + 1 + GN);
                    if ((sOp == OP_ACC) || (sOp == OP_LOAD)) begin
                        modelBusy = 1'b1;
                    end
                end
                if (!expStall) begin
                    adv++;
                end
            end
            checkOutput($sformatf("cfg%0d drained", g), 65'(expSumQ.size()), 65'(0));
            done = 1'b1;
        end
    end

    logic [W:0] held;
    logic [W:0] streamExp[16];
    logic [W-1:0] sa;
    logic [W-1:0] sb;
    int nIssued;
    int nRet;
    int waitCnt;
    int validSeen;

    initial begin
        vecs[0] = '{OP_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 65'h1_0000_0000_0000_0000, 1'b0, 64'd0};
        vecs[1] = '{OP_SUB,  64'd5, 64'd7, 1'b0, 65'h0_FFFF_FFFF_FFFF_FFFE, 1'b0, 64'd0};
        vecs[2] = '{OP_SUB,  64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 65'h0_FFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0};
        vecs[3] = '{OP_ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 65'h0_8000_0000_0000_0000, 1'b1, 64'd0};
        vecs[4] = '{OP_ADD,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 65'h1_0000_0000_0000_0000, 1'b1, 64'd0};
        vecs[5] = '{OP_ADD,  64'h0000_0000_0000_FFFF, 64'h1, 1'b1, 65'h0_0000_0000_0001_0001, 1'b0, 64'd0};
        vecs[6] = '{OP_SUB,  64'd7, 64'd5, 1'b0, 65'h1_0000_0000_0000_0002, 1'b0, 64'd0};
        vecs[7] = '{OP_LOAD, 64'd10, 64'h1234, 1'b1, 65'd10, 1'b0, 64'd10};
        vecs[8] = '{OP_ACC,  64'd3, 64'hFFFF, 1'b1, 65'd13, 1'b0, 64'd13};
        vecs[9] = '{OP_ACC,  64'd3, 64'h0, 1'b0, 65'd16, 1'b0, 64'd16};

        rst_n    = 1'b0;
        inVal    = 1'b0;
        inOp     = OP_ADD;
        inA      = '0;
        inB      = '0;
        inCin    = 1'b0;
        outReady = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rstOutValid", 65'(outValid), 65'(0));
        checkOutput("rstOutSum", outSum, 65'(0));
        checkOutput("rstOutOvf", 65'(outOvf), 65'(0));
        checkOutput("rstAccQ", 65'(accQ), 65'(0));
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            checkOutput($sformatf("v%0d busyWindow", i), 65'(inReady),
                        65'(!((vecs[i].op == OP_ACC) || (vecs[i].op == OP_LOAD))));
            repeat (NSEG - 1) @(negedge clk);
            checkOutput($sformatf("v%0d earlyValid", i), 65'(outValid), 65'(0));
            @(negedge clk);
            checkOutput($sformatf("v%0d latency", i), 65'(outValid), 65'(1));
            checkOutput($sformatf("v%0d sum", i), outSum, vecs[i].expSum);
            checkOutput($sformatf("v%0d ovf", i), 65'(outOvf), 65'(vecs[i].expOvf));
            @(negedge clk);
            checkOutput($sformatf("v%0d retired", i), 65'(outValid), 65'(0));
            checkOutput($sformatf("v%0d accQ", i), 65'(accQ), 65'(vecs[i].expAcc));
            checkOutput($sformatf("v%0d readyAfter", i), 65'(inReady), 65'(1));
        end

        $display("[TB] back-to-back stream with output stall");
        for (int i = 0; i < 16; i++) begin
            sa = {$urandom(), $urandom()};
            sb = {$urandom(), $urandom()};
            streamExp[i] = {1'b0, sa} + {1'b0, sb} + 65'(i % 2);
        end
        nIssued = 0;
        nRet    = 0;
        held    = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            outReady = !(cyc >= 13 && cyc <= 15);
            inVal    = (nIssued < 16);
            inOp     = OP_ADD;
            if (nIssued < 16) begin
                inA   = streamExp[nIssued][W-1:0];
                inB   = '0;
                inCin = 1'b0;
            end
            #1;
            if (cyc >= 13 && cyc <= 15) begin
                checkOutput("stallReady", 65'(inReady), 65'(0));
                checkOutput("stallValid", 65'(outValid), 65'(1));
                if (cyc == 13) begin
                    held = outSum;
                end else begin
                    checkOutput("stallHold", outSum, held);
                end
            end
            if (outValid && outReady) begin
                if (nRet < 16) begin
                    checkOutput($sformatf("stream%0d sum", nRet), outSum,
                                {1'b0, streamExp[nRet][W-1:0]});
                    checkOutput($sformatf("stream%0d cycle", nRet), 65'(cyc),
                                65'((nRet < 8) ? nRet + 5 : nRet + 8));
                end
                nRet++;
            end
            if (inVal && inReady) begin
                nIssued++;
            end
        end
        inVal    = 1'b0;
        outReady = 1'b1;
        checkOutput("streamCount", 65'(nRet), 65'(16));

        $display("[TB] ADD waiting behind an ACC");
        applyStimulus(OP_ACC, 64'd1, 64'd0, 1'b0);
        inVal = 1'b1;
        inOp  = OP_ADD;
        inA   = 64'h100;
        inB   = 64'h23;
        inCin = 1'b0;
        waitCnt = 0;
        #1;
        while (!inReady && waitCnt < 20) begin
            waitCnt++;
            @(negedge clk);
            #1;
        end
        checkOutput("accBusyCycles", 65'(waitCnt), 65'(NSEG + 1));
        checkOutput("accAfterAcc", 65'(accQ), 65'(17));
        @(posedge clk);
        @(negedge clk);
        inVal = 1'b0;
        waitOutValid("waitAddValid");
        checkOutput("waitAddSum", outSum, 65'h123);
        @(negedge clk);

        $display("[TB] reset with ops in flight");
        outReady = 1'b0;
        inVal    = 1'b1;
        inOp     = OP_ADD;
        inA      = 64'h55;
        inB      = 64'h11;
        inCin    = 1'b0;
        waitOutValid("preResetValid");
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("resetOutValid", 65'(outValid), 65'(0));
        checkOutput("resetAccQ", 65'(accQ), 65'(0));
        @(negedge clk);
        rst_n    = 1'b1;
        inVal    = 1'b0;
        outReady = 1'b1;
        validSeen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (outValid) validSeen++;
        end
        checkOutput("noStaleResult", 65'(validSeen), 65'(0));
        applyStimulus(OP_ACC, 64'd5, 64'd9, 1'b1);
        waitOutValid("postResetValid");
        checkOutput("postResetSum", outSum, 65'd5);
        @(negedge clk);
        checkOutput("postResetAcc", 65'(accQ), 65'd5);

        for (int i = 0; i < 20000; i++) begin
            if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) break;
            @(negedge clk);
        end
        checkOutput("sweepDone", 65'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done), 65'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
